// File: rtl/clockwork_ctrl_pkg.sv
// Shared types and constants for the clockwork buffer-port control stage.
package clockwork_ctrl_pkg;

   localparam int CTRL_DEPTH = 3;

   typedef logic [15:0] ctrl_var_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DELAY = 3'd1,
      RUN   = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } ctrl_state_t;

   // Down-counter reload value for an n-cycle wait; zero-length waits never load.
   function automatic ctrl_var_t wait_load(input int unsigned n);
      ctrl_var_t r;
      if (n > 0) begin
         r = ctrl_var_t'(n - 1);
      end else begin
         r = 16'd0;
      end
      return r;
   endfunction

endpackage

// File: rtl/affine_loop_counter.sv
// One loop index of the affine nest: counts 0..ext-1 and flags its terminal value.
module affine_loop_counter
   import clockwork_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      clr,
   input  logic      inc,
   input  ctrl_var_t ext,
   output ctrl_var_t val,
   output logic      wrap
);

   assign wrap = (val == (ext - 16'd1));

   // Index register: cleared on restart, wraps to zero at its terminal value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val <= 16'd0;
      end else if (clr) begin
         val <= 16'd0;
      end else if (inc) begin
         val <= wrap ? 16'd0 : (val + 16'd1);
      end
   end

endmodule

// File: rtl/affine_loop_controller.sv
// Walks a 3-deep affine loop nest and strobes one unified-buffer port (wen/ren)
// with the current loop indices on a fixed start-delay / II / wrap-gap schedule.
module affine_loop_controller
   import clockwork_ctrl_pkg::*;
#(
   parameter int unsigned EXT_0     = 1,
   parameter int unsigned EXT_1     = 64,
   parameter int unsigned EXT_2     = 64,
   parameter int unsigned START_DLY = 0,
   parameter int unsigned II        = 1,
   parameter int unsigned WRAP_GAP  = 0
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        stall,
   output logic                        en,
   output ctrl_var_t [CTRL_DEPTH-1:0]  ctrl_vars,
   output logic                        last,
   output logic                        done
);

   localparam bit        HAS_DLY  = (START_DLY != 0);
   localparam bit        HAS_GAP  = (WRAP_GAP != 0);
   localparam bit        II_ONE   = (II <= 1);
   localparam ctrl_var_t DLY_LOAD = wait_load(START_DLY);
   localparam ctrl_var_t GAP_LOAD = wait_load(WRAP_GAP);
   // After an iteration, II-1 idle cycles follow; the counter reaches zero on the last one.
   localparam ctrl_var_t II_LOAD  = wait_load((II > 1) ? (II - 1) : 0);

   ctrl_state_t state_r, state_nxt;
   logic        en_r, en_nxt;
   logic        done_r, done_nxt;
   ctrl_var_t   ii_cnt_r, ii_nxt;
   ctrl_var_t   wait_cnt_r, wait_nxt;

   logic                  clr_s;
   logic                  adv_s;
   logic                  final_s;
   logic [CTRL_DEPTH-1:0] wrap_s;
   logic [CTRL_DEPTH-1:0] inc_s;

   assign inc_s[2] = adv_s;
   assign inc_s[1] = adv_s & wrap_s[2];
   assign inc_s[0] = adv_s & wrap_s[2] & wrap_s[1];
   assign final_s  = &wrap_s;

   affine_loop_counter u_cnt_0 (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_s),
      .inc  (inc_s[0]),
      .ext  (ctrl_var_t'(EXT_0)),
      .val  (ctrl_vars[0]),
      .wrap (wrap_s[0])
   );

   affine_loop_counter u_cnt_1 (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_s),
      .inc  (inc_s[1]),
      .ext  (ctrl_var_t'(EXT_1)),
      .val  (ctrl_vars[1]),
      .wrap (wrap_s[1])
   );

   affine_loop_counter u_cnt_2 (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_s),
      .inc  (inc_s[2]),
      .ext  (ctrl_var_t'(EXT_2)),
      .val  (ctrl_vars[2]),
      .wrap (wrap_s[2])
   );

   // A stalled cycle withholds the strobe; the pending iteration stays armed in en_r.
   assign en   = en_r & ~stall;
   assign last = en & final_s;
   assign done = done_r;

   // Next-state: flush restarts from any state and overrides stall.
   always_comb begin
      state_nxt = state_r;
      en_nxt    = en_r;
      done_nxt  = done_r;
      ii_nxt    = ii_cnt_r;
      wait_nxt  = wait_cnt_r;
      clr_s     = 1'b0;
      adv_s     = 1'b0;
      if (flush) begin
         clr_s    = 1'b1;
         done_nxt = 1'b0;
         ii_nxt   = 16'd0;
         if (HAS_DLY) begin
            state_nxt = DELAY;
            en_nxt    = 1'b0;
            wait_nxt  = DLY_LOAD;
         end else begin
            state_nxt = RUN;
            en_nxt    = 1'b1;
            wait_nxt  = 16'd0;
         end
      end else if (stall) begin
         state_nxt = state_r;
      end else begin
         case (state_r)
            IDLE: begin
               en_nxt = 1'b0;
            end
            DELAY: begin
               if (wait_cnt_r == 16'd0) begin
                  state_nxt = RUN;
                  en_nxt    = 1'b1;
               end else begin
                  wait_nxt = wait_cnt_r - 16'd1;
               end
            end
            RUN: begin
               if (en_r) begin
                  if (final_s) begin
                     state_nxt = DONE;
                     en_nxt    = 1'b0;
                     done_nxt  = 1'b1;
                  end else begin
                     adv_s = 1'b1;
                     if (HAS_GAP && wrap_s[2]) begin
                        state_nxt = GAP;
                        en_nxt    = 1'b0;
                        wait_nxt  = GAP_LOAD;
                     end else if (II_ONE) begin
                        en_nxt = 1'b1;
                     end else begin
                        en_nxt = 1'b0;
                        ii_nxt = II_LOAD;
                     end
                  end
               end else if (ii_cnt_r == 16'd0) begin
                  en_nxt = 1'b1;
               end else begin
                  ii_nxt = ii_cnt_r - 16'd1;
               end
            end
            GAP: begin
               // The gap is in addition to the normal II spacing.
               if (wait_cnt_r != 16'd0) begin
                  wait_nxt = wait_cnt_r - 16'd1;
               end else if (II_ONE) begin
                  state_nxt = RUN;
                  en_nxt    = 1'b1;
               end else begin
                  state_nxt = RUN;
                  en_nxt    = 1'b0;
                  ii_nxt    = II_LOAD;
               end
            end
            DONE: begin
               en_nxt = 1'b0;
            end
            default: begin
               state_nxt = IDLE;
               en_nxt    = 1'b0;
               done_nxt  = 1'b0;
            end
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         en_r       <= 1'b0;
         done_r     <= 1'b0;
         ii_cnt_r   <= 16'd0;
         wait_cnt_r <= 16'd0;
      end else begin
         state_r    <= state_nxt;
         en_r       <= en_nxt;
         done_r     <= done_nxt;
         ii_cnt_r   <= ii_nxt;
         wait_cnt_r <= wait_nxt;
      end
   end

endmodule

// File: tb/tb_affine_loop_controller.sv
// Directed bench for affine_loop_controller: four parameterisations driven from
// per-cycle stimulus/expectation tables, plus a scoreboarded 64x64 sweep.
module tb_affine_loop_controller;
   import clockwork_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] flush_v = 4'd0;
   logic [3:0] stall_v = 4'd0;

   logic en_a, last_a, done_a, en_b, last_b, done_b;
   logic en_c, last_c, done_c, en_d, last_d, done_d;
   ctrl_var_t [2:0] cv_a, cv_b, cv_c, cv_d;
   logic [50:0] obs [4];

   int errors = 0;
   int checks = 0;
   logic [50:0] exp_q [$];
   logic [1:0]  stim_q [$];

   always #5 clk = ~clk;

   affine_loop_controller #(.EXT_0(1), .EXT_1(2), .EXT_2(3), .START_DLY(0), .II(1), .WRAP_GAP(0)) u_a (
      .clk(clk), .rst(rst), .flush(flush_v[0]), .stall(stall_v[0]),
      .en(en_a), .ctrl_vars(cv_a), .last(last_a), .done(done_a));
   affine_loop_controller #(.EXT_0(1), .EXT_1(2), .EXT_2(2), .START_DLY(4), .II(2), .WRAP_GAP(3)) u_b (
      .clk(clk), .rst(rst), .flush(flush_v[1]), .stall(stall_v[1]),
      .en(en_b), .ctrl_vars(cv_b), .last(last_b), .done(done_b));
   affine_loop_controller #(.EXT_0(1), .EXT_1(64), .EXT_2(64), .START_DLY(0), .II(1), .WRAP_GAP(0)) u_c (
      .clk(clk), .rst(rst), .flush(flush_v[2]), .stall(stall_v[2]),
      .en(en_c), .ctrl_vars(cv_c), .last(last_c), .done(done_c));
   affine_loop_controller #(.EXT_0(1), .EXT_1(1), .EXT_2(1), .START_DLY(0), .II(1), .WRAP_GAP(0)) u_d (
      .clk(clk), .rst(rst), .flush(flush_v[3]), .stall(stall_v[3]),
      .en(en_d), .ctrl_vars(cv_d), .last(last_d), .done(done_d));

   assign obs[0] = {en_a, last_a, done_a, cv_a[0], cv_a[1], cv_a[2]};
   assign obs[1] = {en_b, last_b, done_b, cv_b[0], cv_b[1], cv_b[2]};
   assign obs[2] = {en_c, last_c, done_c, cv_c[0], cv_c[1], cv_c[2]};
   assign obs[3] = {en_d, last_d, done_d, cv_d[0], cv_d[1], cv_d[2]};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One table row: flush, stall, then expected en/last/done and indices as decimal digits c0c1c2.
   task automatic add(input logic f, input logic s, input logic e, input logic l,
                      input logic d, input int v);
      exp_q.push_back({e, l, d, 16'(v / 100), 16'((v / 10) % 10), 16'(v % 10)});
      stim_q.push_back({f, s});
   endtask

   task automatic add_n(input int n, input logic e, input logic l, input logic d, input int v);
      for (int k = 0; k < n; k++) add(1'b0, 1'b0, e, l, d, v);
   endtask

   // Plays the table against instance w, one row per clock, sampling 2ns after input drive.
   task automatic run_seq(input int w, input string tag);
      for (int i = 0; i < exp_q.size(); i++) begin
         flush_v[w] = stim_q[i][1];
         stall_v[w] = stim_q[i][0];
         #2;
         check_eq($sformatf("%s_t%0d", tag, i), 64'(obs[w]), 64'(exp_q[i]));
         @(posedge clk); #1;
      end
      flush_v[w] = 1'b0;
      stall_v[w] = 1'b0;
      exp_q.delete();
      stim_q.delete();
   endtask

   initial begin
      int n, first_t, last_t, done_t, seq_err, last_cnt;

      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) check_eq($sformatf("rst_%0d", k), 64'(obs[k]), 64'd0);
      rst = 1'b0;
      add_n(3, 0, 0, 0, 0);
      run_seq(0, "idle");

      // Basic 1x2x3 sweep, II=1.
      add(1, 0, 0, 0, 0, 0);
      add_n(1, 1, 0, 0, 0);  add_n(1, 1, 0, 0, 1);  add_n(1, 1, 0, 0, 2);
      add_n(1, 1, 0, 0, 10); add_n(1, 1, 0, 0, 11); add_n(1, 1, 1, 0, 12);
      add_n(2, 0, 0, 1, 12);
      run_seq(0, "s2");

      // Stall over the second iteration.
      add(1, 0, 0, 0, 1, 12);
      add(0, 0, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 1);
      add_n(1, 1, 0, 0, 1);  add_n(1, 1, 0, 0, 2);  add_n(1, 1, 0, 0, 10);
      add_n(1, 1, 0, 0, 11); add_n(1, 1, 1, 0, 12); add_n(1, 0, 0, 1, 12);
      run_seq(0, "s5");

      // Flush on the fourth iteration aborts and restarts.
      add(1, 0, 0, 0, 1, 12);
      add_n(1, 1, 0, 0, 0); add_n(1, 1, 0, 0, 1); add_n(1, 1, 0, 0, 2);
      add(1, 0, 1, 0, 0, 10);
      add_n(1, 1, 0, 0, 0);  add_n(1, 1, 0, 0, 1);  add_n(1, 1, 0, 0, 2);
      add_n(1, 1, 0, 0, 10); add_n(1, 1, 0, 0, 11); add_n(1, 1, 1, 0, 12);
      add_n(1, 0, 0, 1, 12);
      run_seq(0, "s6");

      // Flush coincident with the final iteration: no done, immediate restart.
      add(1, 0, 0, 0, 1, 12);
      add_n(1, 1, 0, 0, 0); add_n(1, 1, 0, 0, 1); add_n(1, 1, 0, 0, 2);
      add_n(1, 1, 0, 0, 10); add_n(1, 1, 0, 0, 11);
      add(1, 0, 1, 1, 0, 12);
      add_n(1, 1, 0, 0, 0); add_n(1, 1, 0, 0, 1); add_n(1, 1, 0, 0, 2);
      run_seq(0, "s7");

      // Asynchronous reset mid-sweep, with no clock edge in between.
      #1 rst = 1'b1;
      #1 check_eq("s1_async", 64'(obs[0]), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      add_n(4, 0, 0, 0, 0);
      run_seq(0, "s1_idle");

      // Start delay 4, II 2, wrap gap 3.
      add(1, 0, 0, 0, 0, 0);
      add_n(4, 0, 0, 0, 0);
      add_n(1, 1, 0, 0, 0);  add_n(1, 0, 0, 0, 1);  add_n(1, 1, 0, 0, 1);
      add_n(4, 0, 0, 0, 10); add_n(1, 1, 0, 0, 10); add_n(1, 0, 0, 0, 11);
      add_n(1, 1, 1, 0, 11); add_n(2, 0, 0, 1, 11);
      run_seq(1, "s3");

      // Degenerate single-iteration nest.
      add(1, 0, 0, 0, 0, 0);
      add_n(1, 1, 1, 0, 0);
      add_n(2, 0, 0, 1, 0);
      run_seq(3, "deg");

      // Full 64x64 write-address sweep against a row-major address model.
      n = 0; first_t = -1; last_t = -1; done_t = -1; seq_err = 0; last_cnt = 0;
      flush_v[2] = 1'b1;
      @(posedge clk); #1;
      flush_v[2] = 1'b0;
      for (int t = 1; t <= 4100; t++) begin
         #2;
         if (en_c) begin
            if (n == 0) first_t = t;
            if (cv_c[0] != 16'd0 || cv_c[1] != 16'(n / 64) || cv_c[2] != 16'(n % 64))
               seq_err++;
            n++;
         end
         if (last_c) begin
            last_t = t;
            last_cnt++;
         end
         if (done_c && done_t < 0) done_t = t;
         @(posedge clk); #1;
      end
      check_eq("s4_count", 64'(n), 64'd4096);
      check_eq("s4_first", 64'(first_t), 64'd1);
      check_eq("s4_last", 64'(last_t), 64'd4096);
      check_eq("s4_last_cnt", 64'(last_cnt), 64'd1);
      check_eq("s4_done", 64'(done_t), 64'd4097);
      check_eq("s4_seq_err", 64'(seq_err), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
